// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operation codes, FSM states
// and the signed-overflow rule used by the single-cycle datapath.
package alu_pkg;

    localparam logic [3:0] OP_PASS_S = 4'b0000;
    localparam logic [3:0] OP_PASS_R = 4'b0001;
    localparam logic [3:0] OP_INC    = 4'b0010;
    localparam logic [3:0] OP_DEC    = 4'b0011;
    localparam logic [3:0] OP_ADD    = 4'b0100;
    localparam logic [3:0] OP_SUB    = 4'b0101;
    localparam logic [3:0] OP_SHR    = 4'b0110;
    localparam logic [3:0] OP_SHL    = 4'b0111;
    localparam logic [3:0] OP_AND    = 4'b1000;
    localparam logic [3:0] OP_OR     = 4'b1001;
    localparam logic [3:0] OP_XOR    = 4'b1010;
    localparam logic [3:0] OP_NOT    = 4'b1011;
    localparam logic [3:0] OP_NEG    = 4'b1100;
    localparam logic [3:0] OP_MUL    = 4'b1101;
    localparam logic [3:0] OP_DIV    = 4'b1110;
    localparam logic [3:0] OP_ASR    = 4'b1111;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ITER = 1'b1
    } state_t;

    // Two's-complement overflow from the operand and result sign bits.
    // Only the arithmetic ops can overflow; everything else reports 0.
    function automatic logic calc_v(input logic [3:0] op,
                                    input logic       r_msb,
                                    input logic       s_msb,
                                    input logic       y_msb);
        logic v;
        case (op)
            OP_INC:  v = ~s_msb & y_msb;
            OP_DEC:  v = s_msb & ~y_msb;
            OP_ADD:  v = (r_msb == s_msb) && (y_msb != r_msb);
            OP_SUB:  v = (r_msb != s_msb) && (y_msb != r_msb);
            OP_NEG:  v = s_msb & y_msb;
            default: v = 1'b0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/result bundle of the sequential ALU. The requester drives the
// operation and operands; the ALU returns status, results and flags.
interface seq_alu_if #(parameter int W = 16);

    logic         start;
    logic [3:0]   Alu_op;
    logic [W-1:0] R;
    logic [W-1:0] S;
    logic         busy;
    logic         done;
    logic [W-1:0] Y;
    logic [W-1:0] Y_hi;
    logic         N;
    logic         Z;
    logic         C;
    logic         V;

    modport master (
        output start, Alu_op, R, S,
        input  busy, done, Y, Y_hi, N, Z, C, V
    );

    modport slave (
        input  start, Alu_op, R, S,
        output busy, done, Y, Y_hi, N, Z, C, V
    );

endinterface

// File: rtl/seq_alu_iter.sv
// Iterative engine shared by multiply and divide. One step per enabled
// edge: a shift-add for multiply, a restoring subtract for divide. The
// next-state values are exported so the owner can capture the final step
// on the same edge it is performed.
module seq_alu_iter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         load,
    input  logic         step,
    input  logic         mode,     // 0: multiply, 1: divide
    input  logic [W-1:0] r,
    input  logic [W-1:0] s,
    output logic [W-1:0] lo_next,  // product low word / quotient
    output logic [W-1:0] hi_next   // product high word / remainder
);

    logic [W-1:0] acc;    // product high half / partial remainder
    logic [W-1:0] quot;   // multiplier being shifted out / quotient being built
    logic [W-1:0] m;      // multiplicand / divisor
    logic         mode_q;

    logic [W:0]   sum;
    logic [W:0]   shifted;
    logic [W:0]   diff;

    // One shift-add or restoring-subtract step from the current registers.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and a latch is inferred.
        sum     = '0;
        shifted = '0;
        diff    = '0;
        lo_next = quot;
        hi_next = acc;
        if (!mode_q) begin
            sum     = {1'b0, acc} + (quot[0] ? {1'b0, m} : '0);
            hi_next = sum[W:1];
            lo_next = {sum[0], quot[W-1:1]};
        end else begin
            shifted = {acc, quot[W-1]};
            diff    = shifted - {1'b0, m};
            if (shifted >= {1'b0, m}) begin
                hi_next = diff[W-1:0];
                lo_next = {quot[W-2:0], 1'b1};
            end else begin
                hi_next = shifted[W-1:0];
                lo_next = {quot[W-2:0], 1'b0};
            end
        end
    end

    // Load operands on accept, then advance one step per ITER edge.
    // NOTE: these are pure datapath registers, always loaded before use, so they carry no reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (load) begin
            acc    <= '0;
            quot   <= r;
            m      <= s;
            mode_q <= mode;
        end else if (step) begin
            acc  <= hi_next;
            quot <= lo_next;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with start/busy/done handshake. Single-cycle ops finish
// at the accept edge; multiply and divide run W iterations in ITER.
module seq_alu
    import alu_pkg::*;
#(
    parameter int W  = 16,
    parameter int CW = $clog2(W) + 1
) (
    input  logic  clk,
    input  logic  reset_n,
    seq_alu_if.slave bus
);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          mul_q;

    logic [W:0]    wide;    // {carry, result} of the single-cycle path
    logic [W-1:0]  sc_y;
    logic [W-1:0]  sc_hi;
    logic          sc_c;
    logic          sc_v;
    logic          is_multi;
    logic          accept;
    logic [W-1:0]  it_lo;
    logic [W-1:0]  it_hi;

    // Divide by zero bypasses the iterator and finishes in one cycle.
    assign is_multi = (bus.Alu_op == OP_MUL) ||
                      ((bus.Alu_op == OP_DIV) && (bus.S != '0));
    assign accept   = (state == IDLE) && bus.start;
    assign bus.busy = (state == ITER);

    seq_alu_iter #(.W(W)) u_iter (
        .clk     (clk),
        .load    (accept && is_multi),
        .step    (state == ITER),
        .mode    (bus.Alu_op == OP_DIV),
        .r       (bus.R),
        .s       (bus.S),
        .lo_next (it_lo),
        .hi_next (it_hi)
    );

    // Single-cycle datapath: result and carry as one (W+1)-bit value.
    always_comb begin
        wide  = '0;
        sc_hi = '0;
        case (bus.Alu_op)
            OP_PASS_S: wide = {1'b0, bus.S};
            OP_PASS_R: wide = {1'b0, bus.R};
            OP_INC:    wide = {1'b0, bus.S} + 1'b1;
            OP_DEC:    wide = {1'b0, bus.S} - 1'b1;
            OP_ADD:    wide = {1'b0, bus.R} + {1'b0, bus.S};
            OP_SUB:    wide = {1'b0, bus.R} - {1'b0, bus.S};
            OP_SHR:    wide = {bus.S[0], 1'b0, bus.S[W-1:1]};
            OP_SHL:    wide = {bus.S, 1'b0};
            OP_AND:    wide = {1'b0, bus.R & bus.S};
            OP_OR:     wide = {1'b0, bus.R | bus.S};
            OP_XOR:    wide = {1'b0, bus.R ^ bus.S};
            OP_NOT:    wide = {1'b0, ~bus.S};
            OP_NEG:    wide = {(W+1){1'b0}} - {1'b0, bus.S};
            OP_ASR:    wide = {bus.S[0], bus.S[W-1], bus.S[W-1:1]};
            OP_DIV: begin
                // Only reached with S == 0: saturated quotient, dividend as remainder.
                wide  = {1'b1, {W{1'b1}}};
                sc_hi = bus.R;
            end
            default:   wide = '0;
        endcase
        sc_y = wide[W-1:0];
        sc_c = wide[W];
        sc_v = calc_v(bus.Alu_op, bus.R[W-1], bus.S[W-1], wide[W-1]);
    end

    // FSM, iteration counter and registered results/flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            mul_q    <= 1'b0;
            bus.done <= 1'b0;
            bus.Y    <= '0;
            bus.Y_hi <= '0;
            bus.N    <= 1'b0;
            bus.Z    <= 1'b0;
            bus.C    <= 1'b0;
            bus.V    <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (is_multi) begin
                            state <= ITER;
                            cnt   <= CW'(W);
                            mul_q <= (bus.Alu_op == OP_MUL);
                        end else begin
                            bus.Y    <= sc_y;
                            bus.Y_hi <= sc_hi;
                            bus.N    <= sc_y[W-1];
                            bus.Z    <= (sc_y == '0);
                            bus.C    <= sc_c;
                            bus.V    <= sc_v;
                            bus.done <= 1'b1;
                        end
                    end
                end
                ITER: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state    <= IDLE;
                        bus.Y    <= it_lo;
                        bus.Y_hi <= it_hi;
                        bus.N    <= it_lo[W-1];
                        bus.Z    <= (it_lo == '0);
                        bus.C    <= mul_q && (it_hi != '0);
                        bus.V    <= 1'b0;
                        bus.done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: a W=16 and a W=8 instance, a vector
// table for the single-cycle ops run back-to-back, and hand sequences for
// multiply, divide, ignored start, divide by zero and mid-operation reset.
module tb_seq_alu;
    import alu_pkg::*;

    typedef struct packed {
        logic [15:0] y;
        logic [15:0] y_hi;
        logic        n;
        logic        z;
        logic        c;
        logic        v;
    } res_t;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] r;
        logic [15:0] s;
        res_t        exp;
    } vec_t;

    localparam int NV = 20;

    logic clk = 1'b0;
    logic reset_n;

    seq_alu_if #(.W(16)) bus16 ();
    seq_alu_if #(.W(8))  bus8 ();

    seq_alu #(.W(16)) dut16 (.clk(clk), .reset_n(reset_n), .bus(bus16));
    seq_alu #(.W(8))  dut8  (.clk(clk), .reset_n(reset_n), .bus(bus8));

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    res_t q16[$];
    res_t q8[$];
    vec_t vecs[NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [15:0] r, input logic [15:0] s,
                                input logic [15:0] y, input logic [15:0] y_hi,
                                input logic n, input logic z, input logic c, input logic v);
        vec_t t;
        t.op  = op;
        t.r   = r;
        t.s   = s;
        t.exp = '{y: y, y_hi: y_hi, n: n, z: z, c: c, v: v};
        return t;
    endfunction

    // Scoreboard: every done pulse is compared against the oldest expectation.
    always @(negedge clk) begin
        if (bus16.done) begin
            if (q16.size() == 0) check("unexpected_done16", 64'(bus16.done), 64'd0);
            else check("result16",
                       64'({bus16.Y, bus16.Y_hi, bus16.N, bus16.Z, bus16.C, bus16.V}),
                       64'(q16.pop_front()));
        end
        if (bus8.done) begin
            if (q8.size() == 0) check("unexpected_done8", 64'(bus8.done), 64'd0);
            else check("result8",
                       64'({8'h00, bus8.Y, 8'h00, bus8.Y_hi, bus8.N, bus8.Z, bus8.C, bus8.V}),
                       64'(q8.pop_front()));
        end
    end

    // Counts edges from the accept edge until done is seen; optionally
    // pulses start with a different op while the DUT is busy.
    task automatic wait_done(input bit sel8, input bit poke, output int lat);
        bit busy_ok = 1'b1;
        lat = -1;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (sel8 ? bus8.done : bus16.done) begin
                lat = k;
                break;
            end
            if (sel8 ? !bus8.busy : !bus16.busy) busy_ok = 1'b0;
            if (poke) begin
                bus16.Alu_op = OP_ADD;
                bus16.start  = (k == 5);
            end
            @(posedge clk);
        end
        check(sel8 ? "busy_during_iter8" : "busy_during_iter16", 64'(busy_ok), 64'd1);
    endtask

    initial begin
        int lat;

        vecs[0]  = mk(OP_ADD,    16'h7FFF, 16'h0001, 16'h8000, 16'h0, 1, 0, 0, 1);
        vecs[1]  = mk(OP_SUB,    16'h0000, 16'h0001, 16'hFFFF, 16'h0, 1, 0, 1, 0);
        vecs[2]  = mk(OP_PASS_S, 16'h5678, 16'h1234, 16'h1234, 16'h0, 0, 0, 0, 0);
        vecs[3]  = mk(OP_PASS_R, 16'h8765, 16'h0001, 16'h8765, 16'h0, 1, 0, 0, 0);
        vecs[4]  = mk(OP_INC,    16'h0000, 16'hFFFF, 16'h0000, 16'h0, 0, 1, 1, 0);
        vecs[5]  = mk(OP_INC,    16'h0000, 16'h7FFF, 16'h8000, 16'h0, 1, 0, 0, 1);
        vecs[6]  = mk(OP_DEC,    16'h0000, 16'h0000, 16'hFFFF, 16'h0, 1, 0, 1, 0);
        vecs[7]  = mk(OP_DEC,    16'h0000, 16'h8000, 16'h7FFF, 16'h0, 0, 0, 0, 1);
        vecs[8]  = mk(OP_SHR,    16'h0000, 16'h8001, 16'h4000, 16'h0, 0, 0, 1, 0);
        vecs[9]  = mk(OP_SHL,    16'h0000, 16'h8001, 16'h0002, 16'h0, 0, 0, 1, 0);
        vecs[10] = mk(OP_AND,    16'hF0F0, 16'hFF00, 16'hF000, 16'h0, 1, 0, 0, 0);
        vecs[11] = mk(OP_OR,     16'hF0F0, 16'h0F00, 16'hFFF0, 16'h0, 1, 0, 0, 0);
        vecs[12] = mk(OP_XOR,    16'hFFFF, 16'hFFFF, 16'h0000, 16'h0, 0, 1, 0, 0);
        vecs[13] = mk(OP_NOT,    16'h1234, 16'h0000, 16'hFFFF, 16'h0, 1, 0, 0, 0);
        vecs[14] = mk(OP_NEG,    16'h0000, 16'h8000, 16'h8000, 16'h0, 1, 0, 1, 1);
        vecs[15] = mk(OP_NEG,    16'h0000, 16'h0000, 16'h0000, 16'h0, 0, 1, 0, 0);
        vecs[16] = mk(OP_ASR,    16'h0000, 16'h8001, 16'hC000, 16'h0, 1, 0, 1, 0);
        vecs[17] = mk(OP_ADD,    16'hFFFF, 16'h0001, 16'h0000, 16'h0, 0, 1, 1, 0);
        vecs[18] = mk(OP_SUB,    16'h8000, 16'h0001, 16'h7FFF, 16'h0, 0, 0, 0, 1);
        vecs[19] = mk(OP_DIV,    16'd100,  16'h0000, 16'hFFFF, 16'd100, 1, 0, 1, 0);

        reset_n      = 1'b0;
        bus16.start  = 1'b0;
        bus16.Alu_op = OP_PASS_S;
        bus16.R      = '0;
        bus16.S      = '0;
        bus8.start   = 1'b0;
        bus8.Alu_op  = OP_PASS_S;
        bus8.R       = '0;
        bus8.S       = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs16", 64'({bus16.Y, bus16.Y_hi, bus16.N, bus16.Z, bus16.C, bus16.V}), 64'd0);
        check("reset_busy_done16", 64'({bus16.busy, bus16.done}), 64'd0);
        check("reset_outputs8", 64'({bus8.Y, bus8.Y_hi, bus8.N, bus8.Z, bus8.C, bus8.V, bus8.busy, bus8.done}), 64'd0);
        reset_n = 1'b1;

        // Single-cycle ops back-to-back, one accept per edge.
        for (int i = 0; i < NV; i++) begin
            bus16.Alu_op = vecs[i].op;
            bus16.R      = vecs[i].r;
            bus16.S      = vecs[i].s;
            bus16.start  = 1'b1;
            q16.push_back(vecs[i].exp);
            @(posedge clk);
            @(negedge clk);
            check("done_next_cycle", 64'(bus16.done), 64'd1);
        end
        bus16.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("done_low_after_burst", 64'(bus16.done), 64'd0);
        check("outputs_hold", 64'(bus16.Y), 64'hFFFF);

        // Multiply: inputs change after accept, a start pulsed while busy is ignored.
        bus16.Alu_op = OP_MUL;
        bus16.R      = 16'h1234;
        bus16.S      = 16'h0100;
        bus16.start  = 1'b1;
        q16.push_back('{y: 16'h3400, y_hi: 16'h0012, n: 0, z: 0, c: 1, v: 0});
        @(posedge clk);
        #1;
        bus16.start = 1'b0;
        bus16.R     = 16'hFFFF;
        bus16.S     = 16'hFFFF;
        wait_done(1'b0, 1'b1, lat);
        bus16.start = 1'b0;
        check("mul_latency16", 64'(lat), 64'd16);
        check("busy_clear_at_done", 64'(bus16.busy), 64'd0);
        repeat (3) @(posedge clk);

        // Divide 100 / 7.
        @(negedge clk);
        bus16.Alu_op = OP_DIV;
        bus16.R      = 16'd100;
        bus16.S      = 16'd7;
        bus16.start  = 1'b1;
        q16.push_back('{y: 16'd14, y_hi: 16'd2, n: 0, z: 0, c: 0, v: 0});
        @(posedge clk);
        #1;
        bus16.start = 1'b0;
        wait_done(1'b0, 1'b0, lat);
        check("div_latency16", 64'(lat), 64'd16);

        // Divide by zero completes in one cycle.
        @(negedge clk);
        bus16.Alu_op = OP_DIV;
        bus16.R      = 16'd100;
        bus16.S      = 16'd0;
        bus16.start  = 1'b1;
        q16.push_back('{y: 16'hFFFF, y_hi: 16'd100, n: 1, z: 0, c: 1, v: 0});
        @(posedge clk);
        #1;
        bus16.start = 1'b0;
        wait_done(1'b0, 1'b0, lat);
        check("div0_latency16", 64'(lat), 64'd0);

        // W=8 multiply and decrement boundary.
        @(negedge clk);
        bus8.Alu_op = OP_MUL;
        bus8.R      = 8'hFF;
        bus8.S      = 8'hFF;
        bus8.start  = 1'b1;
        q8.push_back('{y: 16'h0001, y_hi: 16'h00FE, n: 0, z: 0, c: 1, v: 0});
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        wait_done(1'b1, 1'b0, lat);
        check("mul_latency8", 64'(lat), 64'd8);
        @(negedge clk);
        bus8.Alu_op = OP_DEC;
        bus8.S      = 8'h00;
        bus8.start  = 1'b1;
        q8.push_back('{y: 16'h00FF, y_hi: 16'h0000, n: 1, z: 0, c: 1, v: 0});
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        wait_done(1'b1, 1'b0, lat);
        check("dec_latency8", 64'(lat), 64'd0);

        // Reset in the middle of a multiply: result discarded, no done afterwards.
        @(negedge clk);
        bus16.Alu_op = OP_MUL;
        bus16.R      = 16'h00FF;
        bus16.S      = 16'h00FF;
        bus16.start  = 1'b1;
        @(posedge clk);
        #1;
        bus16.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("busy_before_reset", 64'(bus16.busy), 64'd1);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("midop_reset_outputs", 64'({bus16.Y, bus16.Y_hi, bus16.N, bus16.Z, bus16.C, bus16.V}), 64'd0);
        check("midop_reset_busy_done", 64'({bus16.busy, bus16.done}), 64'd0);
        reset_n = 1'b1;
        repeat (25) @(posedge clk);
        @(negedge clk);
        check("idle_after_reset", 64'({bus16.busy, bus16.Y}), 64'd0);

        check("scoreboard16_drained", 64'(q16.size()), 64'd0);
        check("scoreboard8_drained", 64'(q8.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
